// File: rtl/video_timing_gen_pkg.sv
// Shared 1080p60 timing constants and helpers for the timing generator and pixel generators.
package video_timing_gen_pkg;

    localparam int VTG_H_ACTIVE = 1920;
    localparam int VTG_H_FP     = 88;
    localparam int VTG_H_SYNC   = 44;
    localparam int VTG_H_BP     = 148;
    localparam int VTG_H_TOTAL  = VTG_H_ACTIVE + VTG_H_FP + VTG_H_SYNC + VTG_H_BP;

    localparam int VTG_V_ACTIVE = 1080;
    localparam int VTG_V_FP     = 4;
    localparam int VTG_V_SYNC   = 5;
    localparam int VTG_V_BP     = 36;
    localparam int VTG_V_TOTAL  = VTG_V_ACTIVE + VTG_V_FP + VTG_V_SYNC + VTG_V_BP;

    localparam bit VTG_SYNC_POL = 1'b1;

    // True when pos lies in [start, start+len); bounds are truncated to the 16-bit counter domain.
    function automatic logic in_window(input logic [15:0] pos, input int start, input int len);
        return (pos >= 16'(start)) && (pos < 16'(start + len));
    endfunction

endpackage

// File: rtl/vtg_axis_cnt.sv
// One timing axis: a modulo-TOTAL position counter with look-ahead next value and wrap flag.
module vtg_axis_cnt
    import video_timing_gen_pkg::*;
#(
    parameter int TOTAL = VTG_H_TOTAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] count,
    output logic [15:0] count_next,
    output logic        wrap
);

    localparam logic [15:0] LAST = 16'(TOTAL - 1);

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        wrap       = advance && (count == LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (advance) begin
            count_next = count + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y position, data enable, sync pulses and frame start, all registered together.
// Optional frame counter output enabled with `define VTG_FRAME_CNT_EN.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VTG_H_ACTIVE,
    parameter int H_FP     = VTG_H_FP,
    parameter int H_SYNC   = VTG_H_SYNC,
    parameter int H_BP     = VTG_H_BP,
    parameter int V_ACTIVE = VTG_V_ACTIVE,
    parameter int V_FP     = VTG_V_FP,
    parameter int V_SYNC   = VTG_V_SYNC,
    parameter int V_BP     = VTG_V_BP,
    parameter bit SYNC_POL = VTG_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        vde,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic        running;
    logic [15:0] x_next, y_next;
    logic        h_wrap, v_wrap;
    logic        vde_next, hsync_next, vsync_next, frame_start_next;

    // The first enabled edge after reset presents (0,0) rather than advancing past it.
    vtg_axis_cnt #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (en && running),
        .count      (x),
        .count_next (x_next),
        .wrap       (h_wrap)
    );

    vtg_axis_cnt #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (h_wrap),
        .count      (y),
        .count_next (y_next),
        .wrap       (v_wrap)
    );

    // Decode from the next position so the flags land in the same cycle as the coordinates.
    always_comb begin
        vde_next         = (x_next < 16'(H_ACTIVE)) && (y_next < 16'(V_ACTIVE));
        hsync_next       = in_window(x_next, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : !SYNC_POL;
        vsync_next       = in_window(y_next, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : !SYNC_POL;
        frame_start_next = en && (!running || v_wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            vde         <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_start_next;
            if (en) begin
                running <= 1'b1;
                vde     <= vde_next;
                hsync   <= hsync_next;
                vsync   <= vsync_next;
            end
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start_next) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    // Frame counter not built in this configuration.
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster and a reference model feeding a scoreboard.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 3, H_BP = 5;
    localparam int V_ACTIVE = 6,  V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam bit SYNC_POL = 1'b1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        vde;
        logic        hsync;
        logic        vsync;
        logic        frame_start;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] x, y;
    logic        vde, hsync, vsync, frame_start;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    int          m_fc;
`endif

    int   checks   = 0;
    int   failures = 0;
    out_t sb[$];

    // Reference model state
    int   m_x, m_y;
    bit   m_run;
    out_t m_out;
    int   fs_seen, hs_line0;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .x           (x),
        .y           (y),
        .vde         (vde),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
`ifdef VTG_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t model_out(input int px, input int py, input bit fs);
        out_t o;
        o.x           = 16'(px);
        o.y           = 16'(py);
        o.vde         = (px < H_ACTIVE) && (py < V_ACTIVE);
        o.hsync       = (px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
        o.vsync       = (py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
        o.frame_start = fs;
        return o;
    endfunction

    task automatic compare(input string tag);
        out_t obs, exp_v;
        obs   = '{x: x, y: y, vde: vde, hsync: hsync, vsync: vsync, frame_start: frame_start};
        exp_v = sb.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed x=%0d y=%0d vde=%b hs=%b vs=%b fs=%b expected x=%0d y=%0d vde=%b hs=%b vs=%b fs=%b",
                   tag, obs.x, obs.y, obs.vde, obs.hsync, obs.vsync, obs.frame_start,
                   exp_v.x, exp_v.y, exp_v.vde, exp_v.hsync, exp_v.vsync, exp_v.frame_start);
        end
`ifdef VTG_FRAME_CNT_EN
        checks++;
        assert (frame_cnt === 16'(m_fc)) else begin
            failures++;
            $error("FAIL %s_frame_cnt observed=%0d expected=%0d", tag, frame_cnt, m_fc);
        end
`endif
    endtask

    task automatic model_reset();
        m_x   = 0;
        m_y   = 0;
        m_run = 1'b0;
        m_out = '{x: 16'd0, y: 16'd0, vde: 1'b0, hsync: !SYNC_POL, vsync: !SYNC_POL, frame_start: 1'b0};
`ifdef VTG_FRAME_CNT_EN
        m_fc = 0;
`endif
    endtask

    // Drive one clock with the given enable, predict the result, then compare after the edge.
    task automatic step(input logic e, input string tag);
        bit fs;
        en = e;
        if (e) begin
            fs = 1'b0;
            if (!m_run) begin
                m_run = 1'b1;
                fs    = 1'b1;
            end else if (m_x == H_TOTAL - 1) begin
                m_x = 0;
                if (m_y == V_TOTAL - 1) begin
                    m_y = 0;
                    fs  = 1'b1;
                end else begin
                    m_y++;
                end
            end else begin
                m_x++;
            end
            m_out = model_out(m_x, m_y, fs);
`ifdef VTG_FRAME_CNT_EN
            if (fs) m_fc++;
`endif
        end else begin
            m_out.frame_start = 1'b0;
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();

        // Reset state
        #12;
        sb.push_back(m_out);
        compare("reset_state");
        rst_n = 1'b1;

        // Enable low before the first frame: nothing moves
        step(1'b0, "idle_pre_run");
        step(1'b0, "idle_pre_run");

        // One full frame plus a few pixels: first frame start, line wrap, vde/sync windows, frame wrap
        fs_seen  = 0;
        hs_line0 = 0;
        for (int i = 0; i < H_TOTAL * V_TOTAL + 5; i++) begin
            step(1'b1, "run_frame");
            if (frame_start === 1'b1) fs_seen++;
            if (i < H_TOTAL && hsync === SYNC_POL) hs_line0++;
        end
        checks++;
        assert (fs_seen === 2) else begin
            failures++;
            $error("FAIL frame_start_count observed=%0d expected=2", fs_seen);
        end
        checks++;
        assert (hs_line0 === H_SYNC) else begin
            failures++;
            $error("FAIL hsync_width_line0 observed=%0d expected=%0d", hs_line0, H_SYNC);
        end

        // Enable pattern 1,0,0,1 mid-line: position and flags hold, then resume
        while (m_x != 10) step(1'b1, "to_x10");
        step(1'b0, "en_hold");
        step(1'b0, "en_hold");
        step(1'b1, "en_resume");
        step(1'b1, "en_resume");

        // Advance to a point where both syncs are active, then reset asynchronously
        while (!(m_y == V_ACTIVE + V_FP && m_x == H_ACTIVE + H_FP + 1)) step(1'b1, "to_sync");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        sb.push_back(m_out);
        compare("async_reset_midframe");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, "post_reset_first");
        for (int i = 0; i < 3 * H_TOTAL; i++) step(1'b1, "post_reset_run");

        checks++;
        assert (sb.size() === 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL expose parameter H_ACTIVE, default 1920, visible pixels per line.
REQ-002 The block SHALL expose parameter H_FP, default 88, horizontal front porch in clocks.
REQ-003 The block SHALL expose parameter H_SYNC, default 44, hsync pulse width in clocks.
REQ-004 The block SHALL expose parameter H_BP, default 148, horizontal back porch in clocks.
REQ-005 The block SHALL expose parameters V_ACTIVE 1080, V_FP 4, V_SYNC 5, V_BP 36, the vertical equivalents in lines.
REQ-006 The block SHALL expose parameter SYNC_POL, default 1, the active level of hsync and vsync.
REQ-007 clk  in  1  pixel clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en  in  1  pixel-advance enable; counters hold when low.
REQ-010 x  out  16  current horizontal position, 0..H_TOTAL-1.
REQ-011 y  out  16  current vertical position, 0..V_TOTAL-1.
REQ-012 vde  out  1  video data enable, high inside the active area.
REQ-013 hsync, vsync  out  1 each  sync pulses at SYNC_POL level.
REQ-014 frame_start  out  1  one-clock pulse when the position is (0,0).

Function
REQ-015 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (2200 default); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (1125 default).
REQ-016 On each clk edge with en=1, x SHALL increment by 1; at x=H_TOTAL-1 it SHALL wrap to 0 and y SHALL advance.
REQ-017 y SHALL increment only on the x wrap; at y=V_TOTAL-1 with x wrapping, y SHALL wrap to 0.
REQ-018 With en=0, x, y and all derived outputs SHALL hold their values; frame_start SHALL be 0.
REQ-019 vde SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-020 hsync SHALL be at SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else at ~SYNC_POL.
REQ-021 vsync SHALL be at SYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else at ~SYNC_POL.
REQ-022 All outputs SHALL be registered and mutually aligned: vde/hsync/vsync/frame_start in a cycle SHALL describe the x,y presented in that same cycle (zero relative skew).
REQ-023 frame_start SHALL be 1 for exactly one en-qualified cycle per frame, the cycle where x=0 and y=0 are presented.
REQ-024 Counter arithmetic SHALL be 16-bit unsigned; parameter sums exceeding 65535 are unsupported.

Reset
REQ-025 While rst_n=0, x=0, y=0, vde=0, hsync=vsync=~SYNC_POL and frame_start=0, asynchronously.
REQ-026 After rst_n deasserts, the first en-qualified edge SHALL present x=0, y=0, vde=1 and frame_start=1; this is the start of the first frame.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately with no partial sync pulse completion.

Configuration
REQ-028 With VTG_FRAME_CNT_EN defined, the block SHALL add output frame_cnt (16 bits), reset to 0, incremented in the same cycle frame_start is asserted, wrapping 65535->0.
REQ-029 Without VTG_FRAME_CNT_EN, frame_cnt and its register SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the 1080p timing constants (active, porch, sync, totals) and the SYNC_POL default, for use by this block and the pixel generators.
REQ-031 The h and v counters SHALL be a single sub-module, vtg_axis_cnt, instantiated twice (total length, advance input, wrap output).

Verification
REQ-032 Reset then en=1 for 2200 clocks -> x runs 0..2199 then 0, y steps 0->1 exactly at the wrap, frame_start high only on the first cycle.
REQ-033 Line 0 -> vde high for x=0..1919, hsync at SYNC_POL for x=2008..2051 only.
REQ-034 Full frame (2,475,000 clocks) -> vsync active for y=1084..1088, frame_start pulses again at clock 2,475,000, and y wraps from 1124 to 0.
REQ-035 en toggled 1,0,0,1 at x=500 -> x holds 500 through the low cycles, outputs unchanged, then resumes at 501.
REQ-036 rst_n pulsed low at x=2010,y=1085 (both syncs active) -> syncs drop to inactive and x,y go to 0 without waiting for a clock; first post-reset cycle shows frame_start=1.
REQ-037 With VTG_FRAME_CNT_EN and short parameters (H_TOTAL=8, V_TOTAL=4) -> frame_cnt reaches 3 after 96 en cycles, and wraps after 65536 frames.
